// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx: oversampling MAX7219 daisy-chain SPI receiver with per-device shadow registers.
// Define SILIFE_MAX7219_RX_CONFIG_EN to also store decode/intensity/scan-limit/shutdown/test registers.
module silife_max7219_rx #(
  parameter int CHAIN = 16,
  parameter int DEV_BITS = $clog2(CHAIN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_cs,
  input  logic                i_sck,
  input  logic                i_mosi,
  input  logic [DEV_BITS-1:0] i_rd_dev,
  input  logic [2:0]          i_rd_digit,
  output logic [7:0]          o_rd_row,
  output logic [3:0]          o_rd_intensity,
  output logic [2:0]          o_rd_scan_limit,
  output logic [7:0]          o_rd_decode,
  output logic                o_rd_shutdown_n,
  output logic                o_rd_test,
  output logic                o_frame,
  output logic                o_frame_err,
  output logic                o_busy
);
  localparam int NB = 16 * CHAIN;
  localparam int CW = $clog2(NB + 2);
  localparam logic [CW-1:0] FULL = CW'(NB);
  localparam logic [CW-1:0] SAT = CW'(NB + 1);
  logic [1:0] cs_s, sck_s, mosi_s;
  logic cs_h, sck_h;
  logic [CW-1:0] cnt;
  logic [NB-1:0] sr;
  logic [15:0] w [CHAIN];
  logic [7:0] dig [CHAIN][8];
  logic cs_fall, cs_rise, sck_rise, apply, bad, rd_ok;
  assign cs_fall = cs_h & ~cs_s[1];
  assign cs_rise = ~cs_h & cs_s[1];
  assign sck_rise = sck_s[1] & ~sck_h & ~cs_s[1] & ~cs_fall;
  assign apply = cs_rise && cnt == FULL;
  assign bad = cs_rise && cnt != '0 && cnt != FULL;
  assign o_busy = ~cs_s[1];
  assign rd_ok = 32'(i_rd_dev) < CHAIN;
  genvar g;
  for (g = 0; g < CHAIN; g++) begin : g_word
    assign w[g] = sr[16*g +: 16];
  end
  // cs flops reset high so a reset never looks like an active frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cs_s <= 2'b11;
      cs_h <= 1'b1;
      sck_s <= '0;
      sck_h <= 1'b0;
      mosi_s <= '0;
      cnt <= '0;
      sr <= '0;
    end else begin
      cs_s <= {cs_s[0], i_cs};
      sck_s <= {sck_s[0], i_sck};
      mosi_s <= {mosi_s[0], i_mosi};
      cs_h <= cs_s[1];
      sck_h <= sck_s[1];
      if (cs_fall)
        cnt <= '0;
      else if (sck_rise) begin
        sr <= {sr[NB-2:0], mosi_s[1]};
        cnt <= (cnt == SAT) ? SAT : cnt + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_frame <= 1'b0;
      o_frame_err <= 1'b0;
      for (int d = 0; d < CHAIN; d++)
        for (int r = 0; r < 8; r++)
          dig[d][r] <= '0;
    end else begin
      o_frame <= apply;
      o_frame_err <= bad;
      if (apply)
        for (int d = 0; d < CHAIN; d++)
          if (w[d][11:8] != 4'h0 && w[d][11:8] <= 4'h8)
            dig[d][w[d][10:8] - 3'd1] <= w[d][7:0];
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      o_rd_row <= '0;
    else
      o_rd_row <= rd_ok ? dig[i_rd_dev][i_rd_digit] : '0;
`ifdef SILIFE_MAX7219_RX_CONFIG_EN
  logic [7:0] dec [CHAIN];
  logic [3:0] inten [CHAIN];
  logic [2:0] scan [CHAIN];
  logic [CHAIN-1:0] shdn, tst;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shdn <= '0;
      tst <= '0;
      for (int d = 0; d < CHAIN; d++) begin
        dec[d] <= '0;
        inten[d] <= '0;
        scan[d] <= '0;
      end
    end else if (apply)
      for (int d = 0; d < CHAIN; d++) begin
        if (w[d][11:8] == 4'h9) dec[d] <= w[d][7:0];
        if (w[d][11:8] == 4'hA) inten[d] <= w[d][3:0];
        if (w[d][11:8] == 4'hB) scan[d] <= w[d][2:0];
        if (w[d][11:8] == 4'hC) shdn[d] <= w[d][0];
        if (w[d][11:8] == 4'hF) tst[d] <= w[d][0];
      end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_rd_decode <= '0;
      o_rd_intensity <= '0;
      o_rd_scan_limit <= '0;
      o_rd_shutdown_n <= 1'b0;
      o_rd_test <= 1'b0;
    end else begin
      o_rd_decode <= rd_ok ? dec[i_rd_dev] : '0;
      o_rd_intensity <= rd_ok ? inten[i_rd_dev] : '0;
      o_rd_scan_limit <= rd_ok ? scan[i_rd_dev] : '0;
      o_rd_shutdown_n <= rd_ok & shdn[i_rd_dev];
      o_rd_test <= rd_ok & tst[i_rd_dev];
    end
`else
  assign o_rd_decode = '0;
  assign o_rd_intensity = '0;
  assign o_rd_scan_limit = '0;
  assign o_rd_shutdown_n = 1'b0;
  assign o_rd_test = 1'b0;
`endif
endmodule

// File: tb/tb_silife_max7219_rx.sv
// tb_silife_max7219_rx: directed frames through the MAX7219 receiver with hand-computed expectations.
module tb_silife_max7219_rx;
`ifdef SILIFE_MAX7219_RX_CONFIG_EN
  localparam bit CFG = 1'b1;
`else
  localparam bit CFG = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, i_cs = 1'b1, i_sck = 1'b0, i_mosi = 1'b0;
  logic [3:0] i_rd_dev = '0;
  logic [2:0] i_rd_digit = '0;
  logic [7:0] o_rd_row, o_rd_decode;
  logic [3:0] o_rd_intensity;
  logic [2:0] o_rd_scan_limit;
  logic o_rd_shutdown_n, o_rd_test, o_frame, o_frame_err, o_busy;
  logic [271:0] tx;
  int checks = 0, errors = 0, n_frame = 0, n_err = 0;
  silife_max7219_rx #(.CHAIN(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .i_rd_dev(i_rd_dev), .i_rd_digit(i_rd_digit), .o_rd_row(o_rd_row),
    .o_rd_intensity(o_rd_intensity), .o_rd_scan_limit(o_rd_scan_limit),
    .o_rd_decode(o_rd_decode), .o_rd_shutdown_n(o_rd_shutdown_n), .o_rd_test(o_rd_test),
    .o_frame(o_frame), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    n_frame += int'(o_frame);
    n_err += int'(o_frame_err);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic sbit(input logic b);
    i_mosi = b;
    tick(4);
    i_sck = 1'b1;
    tick(4);
    i_sck = 1'b0;
  endtask
  task automatic xfer(input int n);
    i_cs = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) sbit(tx[i]);
    tick(4);
    i_cs = 1'b1;
    tick(6);
  endtask
  task automatic rd(input int dev, input int digit);
    i_rd_dev = 4'(dev);
    i_rd_digit = 3'(digit);
    tick(2);
  endtask
  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(3);
    rd(3, 5);
    check("reset_row", o_rd_row, 8'h00);
    check("reset_shdn", o_rd_shutdown_n, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_pulses", n_frame + n_err, 0);
    tx = '0;
    tx[15:0] = 16'h0A07;
    xfer(256);
    check("f1_frame", n_frame, 1);
    check("f1_err", n_err, 0);
    rd(0, 0);
    check("f1_int_dev0", o_rd_intensity, CFG ? 4'd7 : 4'd0);
    check("f1_row_dev0", o_rd_row, 8'h00);
    rd(1, 0);
    check("f1_int_dev1", o_rd_intensity, 4'd0);
    tx = '0;
    tx[255:240] = 16'h02A5;
    tx[31:16] = 16'h0111;
    tx[47:32] = 16'hF83C;
    tx[63:48] = 16'h0C01;
    tx[79:64] = 16'h0D55;
    tx[95:80] = 16'h0B07;
    tx[111:96] = 16'h09FF;
    tx[127:112] = 16'h0F01;
    xfer(256);
    check("f2_frame", n_frame, 2);
    rd(15, 1);
    check("f2_d15_dig1", o_rd_row, 8'hA5);
    rd(15, 0);
    check("f2_d15_dig0", o_rd_row, 8'h00);
    rd(14, 1);
    check("f2_d14_dig1", o_rd_row, 8'h00);
    rd(1, 0);
    check("f2_d1_dig0", o_rd_row, 8'h11);
    rd(2, 7);
    check("f2_d2_dig7", o_rd_row, 8'h3C);
    rd(3, 0);
    check("f2_d3_shdn", o_rd_shutdown_n, CFG);
    check("f2_d3_row", o_rd_row, 8'h00);
    rd(5, 0);
    check("f2_d5_scan", o_rd_scan_limit, CFG ? 3'd7 : 3'd0);
    rd(6, 0);
    check("f2_d6_dec", o_rd_decode, CFG ? 8'hFF : 8'h00);
    rd(7, 0);
    check("f2_d7_test", o_rd_test, CFG);
    rd(0, 0);
    check("f2_d0_int_kept", o_rd_intensity, CFG ? 4'd7 : 4'd0);
    tx = '0;
    tx[15:0] = 16'h0133;
    tx[16] = 1'b1;
    xfer(255);
    xfer(257);
    check("err_pulses", n_err, 2);
    check("err_no_frame", n_frame, 2);
    rd(0, 0);
    check("err_d0_row", o_rd_row, 8'h00);
    rd(15, 1);
    check("err_d15_row", o_rd_row, 8'hA5);
    i_cs = 1'b0;
    tick(3);
    check("busy_low_cs", o_busy, 1'b1);
    tick(3);
    i_cs = 1'b1;
    tick(6);
    check("nosck_busy", o_busy, 1'b0);
    check("nosck_pulses", n_frame + n_err, 4);
    tx = '0;
    i_cs = 1'b0;
    tick(4);
    for (int i = 0; i < 100; i++) sbit(i[0]);
    reset_n = 1'b0;
    tick(2);
    check("rst_mid_row", o_rd_row, 8'h00);
    check("rst_mid_busy", o_busy, 1'b0);
    reset_n = 1'b1;
    tick(4);
    i_cs = 1'b1;
    tick(6);
    check("rst_stray_rise", n_frame + n_err, 4);
    rd(15, 1);
    check("rst_cleared", o_rd_row, 8'h00);
    tx[15:0] = 16'h0142;
    xfer(256);
    check("rst_frame", n_frame, 3);
    check("rst_err", n_err, 2);
    rd(0, 0);
    check("rst_d0_dig0", o_rd_row, 8'h42);
    check("rst_d0_int", o_rd_intensity, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
